// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port registered word RAM between instruction fetch and load/store.
// Every transaction takes four cycles: IDLE (grant), ISSUE (strobe), WAIT (capture), DONE (ack).
module mem_port_arbiter #(
  parameter int MEM_AW        = 8,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              last_grant_q, last_grant_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant_data;

  // Byte-offset bits and bits above the RAM size are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:MEM_AW+2], i_addr[1:0],
                              d_addr[31:MEM_AW+2], d_addr[1:0]};

  always_comb begin
    if (i_req && d_req) begin
      grant_data = DATA_PRIORITY ? 1'b1 : (last_grant_q == PORT_I);
    end else begin
      grant_data = d_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_addr     = '0;
    mem_rstrb    = 1'b0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          port_d       = grant_data;
          last_grant_d = grant_data;
          addr_d       = grant_data ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
          wdata_d      = grant_data ? d_wdata : '0;
          wmask_d      = grant_data ? d_wmask : '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr = addr_q;
        if (wmask_q == 4'b0000) begin
          mem_rstrb = 1'b1;
        end else begin
          mem_wmask = wmask_q;
          mem_wdata = wdata_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (wmask_q == 4'b0000) begin
          if (port_q == PORT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        i_ack   = (port_q == PORT_I);
        d_ack   = (port_q == PORT_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      port_q       <= PORT_I;
      last_grant_q <= PORT_D;  // instruction side wins the first tie
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus ack scoreboard, priority/reset/latch sequences, random ack-overlap run.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, p_i_req, p_d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_rstrb;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] p_i_rdata, p_d_rdata, p_mem_wdata, p_mem_rdata;
  logic        p_i_ack, p_d_ack, p_mem_rstrb;
  logic [7:0]  p_mem_addr;
  logic [3:0]  p_mem_wmask;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_AW(8), .DATA_PRIORITY(1'b0)) u_dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_AW(8), .DATA_PRIORITY(1'b1)) u_pri (
    .clk(clk), .resetn(resetn),
    .i_req(p_i_req), .i_addr(i_addr), .i_rdata(p_i_rdata), .i_ack(p_i_ack),
    .d_req(p_d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(p_d_rdata), .d_ack(p_d_ack),
    .mem_addr(p_mem_addr), .mem_rstrb(p_mem_rstrb), .mem_wdata(p_mem_wdata),
    .mem_wmask(p_mem_wmask), .mem_rdata(p_mem_rdata)
  );

  // Registered RAM model; the priority instance only ever reads.
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= ram[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (p_mem_rstrb) p_mem_rdata <= ram[p_mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        is_read;
    logic [31:0] rdata;
  } sb_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [7:0]  exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  bit          sb_en = 1'b1;
  logic [31:0] last_d = '0;
  int          overlap = 0;
  vec_t        vecs[9];

  always @(negedge clk) begin
    if (!resetn) last_d = '0;
    if (i_ack && d_ack) overlap++;
    if (sb_en && (i_ack || d_ack)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", {i_ack, d_ack}, 2'b00);
      end else begin
        sb_e = sb_q.pop_front();
        chk("ack_port", {i_ack, d_ack}, sb_e.is_d ? 2'b01 : 2'b10);
        if (sb_e.is_read) chk("ack_rdata", sb_e.is_d ? d_rdata : i_rdata, sb_e.rdata);
        else              chk("store_keeps_d_rdata", d_rdata, last_d);
      end
    end
    if (d_ack) last_d = d_rdata;
  end

  task automatic do_txn(input vec_t v, input bit scramble);
    sb_q.push_back('{v.is_d, v.wmask == 4'h0, v.exp_rdata});
    if (v.is_d) begin
      d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask; d_req = 1'b1;
    end else begin
      i_addr = v.addr; i_req = 1'b1;
    end
    @(posedge clk); #1;
    if (scramble) begin
      d_addr = 32'h80; d_wdata = 32'hFFFF_FFFF;
    end
    chk("issue_addr", mem_addr, v.exp_maddr);
    chk("issue_strobes", {mem_rstrb, mem_wmask}, {v.wmask == 4'h0, v.wmask});
    if (v.wmask != 4'h0) chk("issue_wdata", mem_wdata, v.wdata);
    @(posedge clk); #1;
    if (scramble) d_wdata = 32'h0;
    chk("wait_strobes", {mem_rstrb, mem_wmask, i_ack, d_ack}, 0);
    @(posedge clk); #1;
    chk("ack_in_cycle3", v.is_d ? d_ack : i_ack, 1'b1);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  int p_i_cnt, p_d_cnt, wait_i, wait_d, max_i, max_d, acks;
  bit pend_i, pend_d;

  initial begin
    resetn = 1'b0;
    i_req = 0; d_req = 0; p_i_req = 0; p_d_req = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    for (int i = 0; i < 256; i++) ram[i] <= '0;
    ram[0]   <= 32'h1111_0000;
    ram[2]   <= 32'h0010_0093;
    ram[4]   <= 32'h1234_5678;
    ram[8]   <= 32'h5555_5555;
    ram[32]  <= 32'h0BAD_C0DE;
    ram[255] <= 32'hFFEE_0011;

    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    8'h02, 32'h0010_0093};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 8'h04, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0,    8'h04, 32'h1234_BEEF};
    vecs[3] = '{1'b0, 32'h0000_0403, 32'h0,         4'h0,    8'h00, 32'h1111_0000};
    vecs[4] = '{1'b1, 32'h0000_03FC, 32'h0,         4'h0,    8'hFF, 32'hFFEE_0011};
    vecs[5] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF,    8'hFF, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_07FC, 32'h0,         4'h0,    8'hFF, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0000_00AB, 4'b0001, 8'h08, 32'h0};
    vecs[8] = '{1'b1, 32'h0000_0023, 32'h0,         4'h0,    8'h08, 32'h5555_55AB};

    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {i_ack, d_ack, i_rdata, d_rdata, mem_rstrb, mem_wmask, mem_addr, mem_wdata}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", {i_ack, d_ack, i_rdata, d_rdata, mem_rstrb, mem_wmask, mem_addr, mem_wdata}, 0);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], 1'b0);

    // Requester changes addr/data after the IDLE sample; only the latched values may land.
    do_txn('{1'b1, 32'h40, 32'h1122_3344, 4'hF, 8'h10, 32'h0}, 1'b1);
    @(posedge clk); #1;
    chk("latched_store_data", ram[16], 32'h1122_3344);
    chk("no_store_to_late_addr", ram[32], 32'h0BAD_C0DE);

    // Round-robin from reset with both requests held: i, d, i, d.
    reset_pulse();
    sb_q.push_back('{1'b0, 1'b1, 32'h0010_0093});
    sb_q.push_back('{1'b1, 1'b1, 32'h1234_BEEF});
    sb_q.push_back('{1'b0, 1'b1, 32'h0010_0093});
    sb_q.push_back('{1'b1, 1'b1, 32'h1234_BEEF});
    i_addr = 32'h8; d_addr = 32'h10; d_wmask = 4'h0;
    i_req = 1'b1; d_req = 1'b1;
    repeat (16) @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    chk("rr_all_acked", sb_q.size(), 0);

    // Fixed data priority: data wins every tie while it keeps requesting.
    reset_pulse();
    p_i_cnt = 0; p_d_cnt = 0;
    p_i_req = 1'b1; p_d_req = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (p_d_ack) begin
        p_d_cnt++;
        chk("prio_d_rdata", p_d_rdata, 32'h1234_BEEF);
      end
      if (p_i_ack) p_i_cnt++;
    end
    @(posedge clk); #1;
    p_i_req = 1'b0; p_d_req = 1'b0;
    chk("prio_d_acks", p_d_cnt, 4);
    chk("prio_i_acks", p_i_cnt, 0);

    // Reset during WAIT abandons the fetch; the scoreboard is empty so any ack fails.
    i_addr = 32'h8; i_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_wait_outputs", {i_ack, d_ack, i_rdata, d_rdata, mem_rstrb, mem_wmask, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("quiet_after_reset", {i_ack, d_ack, mem_rstrb, mem_wmask}, 0);
    end
    do_txn(vecs[0], 1'b0);

    // Random traffic: acks must never overlap and neither port may starve.
    sb_en = 1'b0;
    reset_pulse();
    pend_i = 0; pend_d = 0; wait_i = 0; wait_d = 0; max_i = 0; max_d = 0; acks = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (pend_i) begin i_req = 1'b0; pend_i = 1'b0; end
      if (pend_d) begin d_req = 1'b0; pend_d = 1'b0; end
      if (i_req) wait_i++;
      if (d_req) wait_d++;
      if (i_ack) begin pend_i = 1'b1; acks++; if (wait_i > max_i) max_i = wait_i; end
      if (d_ack) begin pend_d = 1'b1; acks++; if (wait_d > max_d) max_d = wait_d; end
      if (!i_req && !pend_i && $urandom_range(0, 3) != 0) begin
        i_addr = $urandom; i_req = 1'b1; wait_i = 0;
      end
      if (!d_req && !pend_d && $urandom_range(0, 3) != 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
        d_req = 1'b1; wait_d = 0;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("random_acks_seen", acks > 100, 1'b1);
    chk("starve_bound_i", max_i <= 8, 1'b1);
    chk("starve_bound_d", max_d <= 8, 1'b1);
    chk("ack_overlap", overlap, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the SOC's single-port word memory between two requesters: the instruction-fetch side (read-only) and the load/store side (read/write, byte-masked).
- Sits between the CPU state machine and the memory array. Replaces the CPU's direct combinational access to the memory, so loads and stores can reach the same memory that fetch uses.
- Each transaction is a fixed 4-cycle handshake.
- Arbitration is round-robin, or optionally fixed priority to data.

Parameters:
- MEM_AW, 8, word-address width of the memory (256 words).
- DATA_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = data port always wins ties.

Ports:
- clk  in  1  system clock (from Clockworks)
- resetn  in  1  synchronous active-low reset
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  32  instruction byte address
- i_rdata  out  32  instruction read data; valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wmask  in  4  byte-write enables; 0000 = load, nonzero = store
- d_rdata  out  32  load data; valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse, data port
- mem_addr  out  MEM_AW  memory word address
- mem_rstrb  out  1  memory read strobe
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte-write enables
- mem_rdata  in  32  memory read data; valid the cycle after mem_rstrb (registered RAM)

Behaviour:
- Synchronous reset, checked on every posedge clk while resetn=0:
  - state=IDLE; i_ack=d_ack=0; i_rdata=d_rdata=0
  - mem_rstrb=0; mem_wmask=0; mem_addr=0; mem_wdata=0
  - last_grant=DATA, so the instruction port wins the first tie.
- Reset mid-transaction abandons it with no ack. A store already driven to memory in ISSUE is not rolled back.
- Address mapping: mem_addr = addr[MEM_AW+1:2]. Bits [1:0] and bits above MEM_AW+1 are ignored, so addresses wrap modulo 4*2^MEM_AW bytes.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant it.
  - Both high, DATA_PRIORITY=1: grant data.
  - Both high, DATA_PRIORITY=0: grant the port that is not last_grant.
  - On grant: latch port id, word address, wdata and wmask into internal registers; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_addr = latched address.
  - Load/fetch: mem_rstrb=1, mem_wmask=0.
  - Store: mem_wmask=latched mask, mem_wdata=latched data, mem_rstrb=0.
  - Go to WAIT.
- WAIT:
  - mem_rstrb=0; mem_wmask=0.
  - For a read, capture mem_rdata into the granted port's rdata register at the end of the cycle.
  - Go to DONE.
- DONE:
  - The granted port's ack=1 for this single cycle; the other ack=0.
  - rdata holds the captured value. For a store, d_rdata is unchanged from its previous value.
  - Requests are ignored in this cycle. The requester drops req at the clock edge that ends DONE.
  - Go to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle 0 → ack high in cycle 3.
  - Back-to-back transactions from one port start every 4 cycles.
  - A req still high in the IDLE after DONE is treated as a new transaction.
- Outside ISSUE, mem_rstrb=0 and mem_wmask=0 always.
- At most one ack is high in any cycle. The two acks are never high together.
- Requester contract: addr, wdata and wmask must be stable only in the IDLE cycle where req is sampled. They are latched, so later changes have no effect on the transaction in flight.
- Starvation bound (DATA_PRIORITY=0): with both ports requesting continuously, grants alternate I, D, I, D. Each port waits at most 8 cycles from req to ack.

Test Plan:
- Reset with both req=0, then release → all outputs 0 and state IDLE. Then i_req with i_addr=0x8, memory word 2 = 0x00100093 → mem_rstrb=1 in cycle 1 with mem_addr=2; i_ack=1 and i_rdata=0x00100093 in cycle 3.
- d_req store, d_addr=0x10, d_wdata=0xDEADBEEF, d_wmask=0011 → mem_wmask=0011, mem_addr=4, mem_wdata=0xDEADBEEF for one cycle; d_ack in cycle 3. Follow-up load from 0x10 over old value 0x12345678 → d_rdata=0x1234BEEF.
- i_req and d_req raised together, held and re-raised for 4 transactions, DATA_PRIORITY=0 → ack order i, d, i, d starting from reset. Same stimulus with DATA_PRIORITY=1 → d, d, d, d while d_req stays high.
- i_addr=0x403, MEM_AW=8 → mem_addr=0x00 (wrap, low bits ignored). d_addr=0x3FC → mem_addr=0xFF.
- resetn=0 asserted during WAIT of a load → no ack in any subsequent cycle, mem strobes 0. After release, a new i_req completes normally in 4 cycles.
- Change d_addr and d_wdata in ISSUE and WAIT of a store → memory sees only the values sampled in IDLE. Also check that i_ack and d_ack are never high together over a 1000-cycle random-request run.
